// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, Booth digit
// encoding and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } stateT;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } boothDigitT;

    // One extra digit beyond N/2 so zero-extended unsigned operands recode exactly.
    function automatic int iter_count(input int n);
        return n / 2 + 1;
    endfunction

    function automatic boothDigitT recodeDigit(input logic [2:0] bits);
        boothDigitT digit;
        case (bits)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational Booth radix-4 recoder: turns three multiplier bits into the
// partial-product addend and carry-in that are applied to the accumulator.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   mBits,
    input  logic [N+1:0] multiplicand,
    output logic [N+2:0] addend,
    output logic         carryIn
);

    boothDigitT  digit;
    logic [N+2:0] oneA;
    logic [N+2:0] twoA;

    assign digit = recodeDigit(mBits);
    assign oneA  = {multiplicand[N+1], multiplicand};
    assign twoA  = {multiplicand, 1'b0};

    // Negative digits use one's complement here; the +1 arrives as carryIn.
    always_comb begin
        addend  = '0;
        carryIn = 1'b0;
        case (digit)
            POS1: addend = oneA;
            POS2: addend = twoA;
            NEG1: begin
                addend  = ~oneA;
                carryIn = 1'b1;
            end
            NEG2: begin
                addend  = ~twoA;
                carryIn = 1'b1;
            end
            default: begin
                addend  = '0;
                carryIn = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock, with the
// start/done handshake shared by the SRT divider.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signedInput,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p,
    output logic           done,
    output logic           busy
);

    localparam int ITER = iter_count(N);
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    stateT          state;
    stateT          nextState;
    logic [CW-1:0]  count;
    logic [N+1:0]   aReg;
    logic [N+1:0]   mReg;
    logic           mPrev;
    logic [N+2:0]   acc;

    logic           accept;
    logic [N+1:0]   aExt;
    logic [N+1:0]   bExt;
    logic [N+2:0]   addend;
    logic           carryIn;
    logic [N+2:0]   sum;
    logic [2*N+4:0] shifted;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign aExt   = signedInput ? {{2{a[N-1]}}, a} : {2'b00, a};
    assign bExt   = signedInput ? {{2{b[N-1]}}, b} : {2'b00, b};

    booth_r4_recoder #(.N(N)) recoder (
        .mBits        ({mReg[1], mReg[0], mPrev}),
        .multiplicand (aReg),
        .addend       (addend),
        .carryIn      (carryIn)
    );

    always_comb begin
        sum     = acc + addend + {{(N+2){1'b0}}, carryIn};
        shifted = $signed({sum, mReg}) >>> 2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (count == LAST) nextState = DONE;
            DONE:    if (start) nextState = RUN;
            default: nextState = IDLE;
        endcase
    end

    // Product bits shift into mReg from the top as multiplier bits retire below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            aReg  <= '0;
            mReg  <= '0;
            mPrev <= 1'b0;
            acc   <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else if (accept) begin
            count <= '0;
            aReg  <= aExt;
            mReg  <= bExt;
            mPrev <= 1'b0;
            acc   <= '0;
            done  <= 1'b0;
        end else if (state == RUN) begin
            acc   <= shifted[2*N+4:N+2];
            mReg  <= shifted[N+1:0];
            mPrev <= mReg[1];
            count <= count + CW'(1);
            if (count == LAST) begin
                p    <= shifted[2*N-1:0];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Scoreboard bench for booth_r4_multiplier (N=32): directed corner cases,
// asynchronous reset mid-run and back-to-back random operations.
module tb_booth_r4_multiplier;

    localparam int N    = 32;
    localparam int ITER = 17;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           signedInput = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic [2*N-1:0] p;
    logic           done;
    logic           busy;

    int testsRun = 0;
    int failures = 0;
    logic [63:0] expQ[$];

    booth_r4_multiplier #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signedInput (signedInput),
        .a           (a),
        .b           (b),
        .p           (p),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] refMul(input bit s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, actual, expected);
        end
    endtask

    // Accept one operation, optionally hammer start/operands during RUN, then
    // wait (bounded) for done and compare against the scoreboard head.
    task automatic applyStimulus(input bit s, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [63:0] expP, input bit holdStart, input string tag);
        int lat;
        logic [63:0] expHead;
        @(negedge clk);
        signedInput = s;
        a = av;
        b = bv;
        start = 1'b1;
        expQ.push_back(expP);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_doneLowAfterAccept"}, 64'(done), 64'd0);
        checkOutput({tag, "_busyAfterAccept"}, 64'(busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= ITER + 4; i++) begin
            @(negedge clk);
            if (holdStart) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
                signedInput = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        expHead = expQ.pop_front();
        checkOutput({tag, "_latency"}, 64'(lat), 64'(ITER));
        checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'd0);
        checkOutput({tag, "_product"}, p, expHead);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;

        #2;
        checkOutput("reset_p", p, 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, "uMax");
        applyStimulus(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1'b0, "sNeg3x7");
        applyStimulus(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, "sMinSq");
        applyStimulus(1'b1, 32'h80000000, 32'd2, 64'hFFFFFFFF00000000, 1'b0, "sMinX2");
        applyStimulus(1'b0, 32'h80000000, 32'd2, 64'h0000000100000000, 1'b0, "uMinX2");

        // Reset asserted between clock edges during RUN must clear outputs at once.
        @(negedge clk);
        signedInput = 1'b0;
        a = 32'd123;
        b = 32'd456;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRunReset_p", p, 64'd0);
        checkOutput("midRunReset_done", 64'(done), 64'd0);
        checkOutput("midRunReset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd10, 32'd10, 64'd100, 1'b0, "afterReset");

        applyStimulus(1'b0, 32'd5, 32'd6, 64'd30, 1'b1, "holdStart");
        applyStimulus(1'b0, 32'd0, 32'h1234, 64'd0, 1'b0, "zeroFromDone");

        for (int i = 0; i < 2000; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            applyStimulus(rs, ra, rb, refMul(rs, ra, rb), 1'b0, "random");
        end

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
